// File: rtl/capture_readout_sequencer_pkg.sv
// Shared definitions for the capture/readout sequencer: one-hot state encoding
// and record framing constants.
package capture_readout_sequencer_pkg;

   typedef enum logic [9:0] {
      IDLE      = 10'b00_0000_0001,
      TRIG      = 10'b00_0000_0010,
      HOLDOFF   = 10'b00_0000_0100,
      WAIT_DATA = 10'b00_0000_1000,
      FETCH     = 10'b00_0001_0000,
      LATCH     = 10'b00_0010_0000,
      SEND_HDR  = 10'b00_0100_0000,
      SEND_HI   = 10'b00_1000_0000,
      SEND_LO   = 10'b01_0000_0000,
      SEND_CSUM = 10'b10_0000_0000
   } seqState_t;

   localparam int          WORDS_PER_RECORD_DEF = 128;
   localparam int          HOLDOFF_CYC_DEF      = 16;
   localparam logic [23:0] TIMEOUT_CYC_DEF      = 24'd5000000;
   localparam logic [7:0]  HEADER_BYTE_DEF      = 8'hA5;

   // FIFO dout must arrive within this many cycles of entering LATCH.
   localparam logic [23:0] LATCH_WAIT_CYC       = 24'd4;

endpackage

// File: rtl/capture_readout_sequencer_tx_byte_reg.sv
// Valid/ready holding register for the UART byte stream, with the running XOR
// checksum of the data bytes accepted so far.
module tx_byte_reg
   import capture_readout_sequencer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       loadCsum,
   input  logic [7:0] loadData,
   input  logic       csumEn,
   input  logic       csumClr,
   input  logic       drop,
   input  logic       txReady,
   output logic [7:0] txData,
   output logic       txValid
);

   logic [7:0] csum;
   logic [7:0] csumNext;
   logic       accept;

   assign accept = txValid & txReady;

   // The byte being accepted this cycle is already folded in, so the checksum
   // can be loaded back-to-back with the last data byte.
   assign csumNext = (accept && csumEn) ? (csum ^ txData) : csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         txValid <= 1'b0;
         txData  <= '0;
      end else if (drop) begin
         txValid <= 1'b0;
      end else if (load) begin
         txValid <= 1'b1;
         txData  <= loadCsum ? csumNext : loadData;
      end else if (accept) begin
         txValid <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         csum <= '0;
      end else if (csumClr) begin
         csum <= '0;
      end else begin
         csum <= csumNext;
      end
   end

endmodule

// File: rtl/capture_readout_sequencer.sv
// Sequences one acquisition record: arm, N capture strobes, then drains the
// transfer FIFO as a framed byte stream (header, data bytes, XOR checksum).
//
// state     | meaning
// IDLE      | waiting for armCmd
// TRIG      | waiting for auto/external trigger, timeout running
// HOLDOFF   | dead time after a strobe
// WAIT_DATA | readout granted, waiting for first FIFO word
// FETCH     | issue FIFO read once a word is available
// LATCH     | wait for FIFO dout valid, underflow guard running
// SEND_HDR  | header byte on the TX port
// SEND_HI   | word[15:8] on the TX port
// SEND_LO   | word[7:0] on the TX port
// SEND_CSUM | checksum byte on the TX port
module capture_readout_sequencer
   import capture_readout_sequencer_pkg::*;
#(
   parameter int          WORDS_PER_RECORD = WORDS_PER_RECORD_DEF,
   parameter int          HOLDOFF_CYC      = HOLDOFF_CYC_DEF,
   parameter logic [23:0] TIMEOUT_CYC      = TIMEOUT_CYC_DEF,
   parameter logic [7:0]  HEADER_BYTE      = HEADER_BYTE_DEF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        armCmd,
   input  logic        abortCmd,
   input  logic [7:0]  numEventsCfg,
   input  logic        autoTrig,
   input  logic        extTrig,
   output logic        captureStrobe,
   output logic [7:0]  numEvents,
   output logic        readyToTransmit,
   input  logic        dataReadyToRead,
   output logic        dataRead,
   input  logic        dataValid,
   input  logic [15:0] dataIn,
   output logic [7:0]  txData,
   output logic        txValid,
   input  logic        txReady,
   output logic        busy,
   output logic        timeoutErr
);

   localparam logic [23:0] HOLDOFF_LOAD = 24'(HOLDOFF_CYC - 1);
   localparam logic [23:0] TIMEOUT_LOAD = TIMEOUT_CYC - 24'd1;
   localparam logic [23:0] LATCH_LOAD   = LATCH_WAIT_CYC - 24'd1;
   localparam logic [7:0]  LAST_WORD    = 8'(WORDS_PER_RECORD - 1);

   seqState_t   state;
   seqState_t   stateNext;

   logic        extTrigQ;
   logic        trigger;
   logic        accept;
   logic [7:0]  evtCnt;
   logic [7:0]  wordCnt;
   logic [23:0] timer;
   logic [15:0] wordReg;

   logic        armAccept;
   logic        evtInc;
   logic        wordInc;
   logic        wordCapture;
   logic        errSet;
   logic        strobeSet;
   logic        readSet;
   logic        timerLoad;
   logic [23:0] timerLoadVal;
   logic        txLoad;
   logic        txLoadCsum;
   logic [7:0]  txLoadData;
   logic        csumEn;
   logic        txDrop;

   assign trigger         = autoTrig | (extTrig & ~extTrigQ);
   assign accept          = txValid & txReady;
   assign busy            = (state != IDLE);
   assign readyToTransmit = state inside {WAIT_DATA, FETCH, LATCH, SEND_HDR,
                                          SEND_HI, SEND_LO, SEND_CSUM};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_comb begin
      stateNext    = state;
      armAccept    = 1'b0;
      evtInc       = 1'b0;
      wordInc      = 1'b0;
      wordCapture  = 1'b0;
      errSet       = 1'b0;
      strobeSet    = 1'b0;
      readSet      = 1'b0;
      timerLoad    = 1'b0;
      timerLoadVal = '0;
      txLoad       = 1'b0;
      txLoadCsum   = 1'b0;
      txLoadData   = '0;
      csumEn       = 1'b0;
      txDrop       = 1'b0;

      if (abortCmd) begin
         stateNext = IDLE;
         txDrop    = 1'b1;
      end else begin
         unique case (state)
            IDLE: begin
               if (armCmd) begin
                  armAccept    = 1'b1;
                  timerLoad    = 1'b1;
                  timerLoadVal = TIMEOUT_LOAD;
                  stateNext    = TRIG;
               end
            end
            TRIG: begin
               if (trigger) begin
                  strobeSet    = 1'b1;
                  evtInc       = 1'b1;
                  timerLoad    = 1'b1;
                  timerLoadVal = HOLDOFF_LOAD;
                  stateNext    = HOLDOFF;
               end else if (timer == '0) begin
                  errSet    = 1'b1;
                  stateNext = IDLE;
               end
            end
            HOLDOFF: begin
               if (timer == '0) begin
                  if (evtCnt == numEvents) begin
                     stateNext = WAIT_DATA;
                  end else begin
                     timerLoad    = 1'b1;
                     timerLoadVal = TIMEOUT_LOAD;
                     stateNext    = TRIG;
                  end
               end
            end
            WAIT_DATA: begin
               if (dataReadyToRead) begin
                  txLoad     = 1'b1;
                  txLoadData = HEADER_BYTE;
                  stateNext  = SEND_HDR;
               end
            end
            SEND_HDR: begin
               if (accept) begin
                  stateNext = FETCH;
               end
            end
            FETCH: begin
               if (dataReadyToRead) begin
                  readSet      = 1'b1;
                  timerLoad    = 1'b1;
                  timerLoadVal = LATCH_LOAD;
                  stateNext    = LATCH;
               end
            end
            LATCH: begin
               if (dataValid) begin
                  wordCapture = 1'b1;
                  txLoad      = 1'b1;
                  txLoadData  = dataIn[15:8];
                  stateNext   = SEND_HI;
               end else if (timer == '0) begin
                  errSet    = 1'b1;
                  stateNext = IDLE;
               end
            end
            SEND_HI: begin
               csumEn = 1'b1;
               if (accept) begin
                  txLoad     = 1'b1;
                  txLoadData = wordReg[7:0];
                  stateNext  = SEND_LO;
               end
            end
            SEND_LO: begin
               csumEn = 1'b1;
               if (accept) begin
                  wordInc = 1'b1;
                  if (wordCnt == LAST_WORD) begin
                     txLoad     = 1'b1;
                     txLoadCsum = 1'b1;
                     stateNext  = SEND_CSUM;
                  end else begin
                     stateNext = FETCH;
                  end
               end
            end
            SEND_CSUM: begin
               if (accept) begin
                  stateNext = IDLE;
               end
            end
            default: begin
               stateNext = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         extTrigQ      <= 1'b0;
         captureStrobe <= 1'b0;
         dataRead      <= 1'b0;
         timer         <= '0;
      end else begin
         extTrigQ      <= extTrig;
         captureStrobe <= strobeSet;
         dataRead      <= readSet;
         if (timerLoad) begin
            timer <= timerLoadVal;
         end else if (timer != '0) begin
            timer <= timer - 24'd1;
         end
      end
   end

   // A zero event count still produces one strobe per record.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         numEvents  <= '0;
         evtCnt     <= '0;
         wordCnt    <= '0;
         wordReg    <= '0;
         timeoutErr <= 1'b0;
      end else begin
         if (armAccept) begin
            numEvents  <= (numEventsCfg == 8'd0) ? 8'd1 : numEventsCfg;
            evtCnt     <= '0;
            wordCnt    <= '0;
            timeoutErr <= 1'b0;
         end else begin
            if (evtInc) begin
               evtCnt <= evtCnt + 8'd1;
            end
            if (wordInc) begin
               wordCnt <= wordCnt + 8'd1;
            end
            if (errSet) begin
               timeoutErr <= 1'b1;
            end
         end
         if (wordCapture) begin
            wordReg <= dataIn;
         end
      end
   end

   tx_byte_reg uTxByteReg (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (txLoad),
      .loadCsum (txLoadCsum),
      .loadData (txLoadData),
      .csumEn   (csumEn),
      .csumClr  (armAccept),
      .drop     (txDrop),
      .txReady  (txReady),
      .txData   (txData),
      .txValid  (txValid)
   );

endmodule
